pong_engine: RTL and testbench

Parametrised second-generation Pong game-state engine on the 25.175 MHz pixel clock. It owns the ball, two paddles, scores and a serve/play/game-over state machine. It feeds sprite coordinates and scores to the renderer. Compared with the first-generation logic, it adds parametrised geometry, scoring on goal-wall hits, timed serves, a speed-up on each paddle hit, paddle clamping and a match end.

---
 rtl/pong_engine.sv | 270 +++++++++++++++++++++++++++
 tb/tb_pong_engine.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// pong_engine: game-state engine for a two-player Pong renderer.
// Owns ball position/direction, both paddles, scores and the
// IDLE -> SERVE -> PLAY -> OVER sequence. Every output is a register on clk_0.
module pong_engine #(
  parameter int H_VIDEO      = 640,
  parameter int V_VIDEO      = 480,
  parameter int BALL_SIZE    = 16,
  parameter int PDL_W        = 12,
  parameter int PDL_H        = 96,
  parameter int PDL1_X       = 24,
  parameter int PDL2_X       = 603,
  parameter int CLK_HZ       = 25_175_000,
  parameter int BALL_VEL     = 200,
  parameter int PDL_VEL      = 200,
  parameter int PSC_STEP     = 4096,
  parameter int PSC_MIN      = 41_958,
  parameter int SERVE_CYCLES = 25_175_000,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9
) (
  input  logic               clk_0,
  input  logic               rst,
  input  logic               start,
  input  logic               up_p1,
  input  logic               down_p1,
  input  logic               up_p2,
  input  logic               down_p2,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic [9:0]         pdl1_y,
  output logic [9:0]         pdl2_y,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         state,
  output logic               winner,
  output logic               point_p1,
  output logic               point_p2,
  output logic               hit
);

  localparam int BALL_PSC0 = CLK_HZ / BALL_VEL;
  localparam int PDL_PSC   = CLK_HZ / PDL_VEL;
  // One counter serves both the serve pause and the ball step prescaler.
  localparam int CNT_MAX   = (BALL_PSC0 > SERVE_CYCLES) ? BALL_PSC0 : SERVE_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int PW        = $clog2(PDL_PSC + 1);

  localparam logic [9:0]  BX0    = 10'((H_VIDEO - BALL_SIZE) / 2);
  localparam logic [9:0]  BY0    = 10'((V_VIDEO - BALL_SIZE) / 2);
  localparam logic [9:0]  PY0    = 10'((V_VIDEO - PDL_H) / 2);
  localparam logic [9:0]  X_MAX  = 10'(H_VIDEO - BALL_SIZE);
  localparam logic [9:0]  Y_MAX  = 10'(V_VIDEO - BALL_SIZE);
  localparam logic [9:0]  PY_MAX = 10'(V_VIDEO - PDL_H);
  localparam logic [9:0]  HIT1_X = 10'(PDL1_X + PDL_W);
  localparam logic [10:0] HIT2_X = 11'(PDL2_X);

  localparam logic [CW-1:0]      PSC0       = CW'(BALL_PSC0);
  localparam logic [CW-1:0]      PSC_FLOOR  = CW'(PSC_MIN);
  localparam logic [CW-1:0]      PSC_DEC    = CW'(PSC_STEP);
  localparam logic [CW-1:0]      SERVE_LAST = CW'(SERVE_CYCLES - 1);
  localparam logic [PW-1:0]      PDL_LAST   = PW'(PDL_PSC - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

  state_t              st_q, st_n;
  logic [CW-1:0]       cnt_q, cnt_n, psc_q, psc_n;
  logic                xdir_q, xdir_n;   // 1 = moving right
  logic                ydir_q, ydir_n;   // 1 = moving down
  logic [9:0]          bx_n, by_n;
  logic [SCORE_W-1:0]  s1_n, s2_n, s1_inc, s2_inc;
  logic                win_n, pp1_n, pp2_n, hit_n;
  logic [10:0]         by_w, p1_w, p2_w, bx_right;
  logic                ovl1, ovl2, ball_tick;
  logic [PW-1:0]       pc1_q, pc2_q;
  logic                mv1, mv2;

  assign state = st_q;

  // Widen to 11 bits so the paddle/ball sums can never wrap.
  assign by_w     = {1'b0, ball_y};
  assign p1_w     = {1'b0, pdl1_y};
  assign p2_w     = {1'b0, pdl2_y};
  assign bx_right = {1'b0, ball_x} + 11'(BALL_SIZE);
  assign ovl1     = (by_w + 11'(BALL_SIZE) > p1_w) && (by_w < p1_w + 11'(PDL_H));
  assign ovl2     = (by_w + 11'(BALL_SIZE) > p2_w) && (by_w < p2_w + 11'(PDL_H));

  assign ball_tick = (cnt_q == psc_q - CW'(1));
  assign s1_inc    = (score1 == SCORE_MAX) ? score1 : score1 + SCORE_W'(1);
  assign s2_inc    = (score2 == SCORE_MAX) ? score2 : score2 + SCORE_W'(1);

  // Game state register.
  // NOTE: registers use non-blocking (<=) so every flop updates from pre-edge values.
  always_ff @(posedge clk_0) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_n;
  end

  // Next-state, ball step, scoring and event pulses.
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    st_n   = st_q;
    cnt_n  = cnt_q;
    psc_n  = psc_q;
    xdir_n = xdir_q;
    ydir_n = ydir_q;
    bx_n   = ball_x;
    by_n   = ball_y;
    s1_n   = score1;
    s2_n   = score2;
    win_n  = winner;
    pp1_n  = 1'b0;
    pp2_n  = 1'b0;
    hit_n  = 1'b0;
    case (st_q)
      IDLE, OVER: begin
        bx_n = BX0;
        by_n = BY0;
        if (start) begin
          s1_n   = '0;
          s2_n   = '0;
          xdir_n = 1'b0;
          cnt_n  = '0;
          st_n   = SERVE;
        end
      end
      SERVE: begin
        bx_n   = BX0;
        by_n   = BY0;
        ydir_n = 1'b0;
        if (cnt_q == SERVE_LAST) begin
          cnt_n = '0;
          st_n  = PLAY;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      PLAY: begin
        if (!ball_tick) begin
          cnt_n = cnt_q + CW'(1);
        end else begin
          cnt_n = '0;
          // Vertical: bounce off top/bottom walls.
          if (ydir_q && ball_y == Y_MAX) begin
            ydir_n = 1'b0;
            by_n   = ball_y - 10'd1;
          end else if (!ydir_q && ball_y == 10'd0) begin
            ydir_n = 1'b1;
            by_n   = ball_y + 10'd1;
          end else begin
            by_n = ydir_q ? ball_y + 10'd1 : ball_y - 10'd1;
          end
          // Horizontal: paddle hits win over goals.
          if (!xdir_q && ball_x == HIT1_X && ovl1) begin
            xdir_n = 1'b1;
            bx_n   = ball_x + 10'd1;
            hit_n  = 1'b1;
            psc_n  = (int'(psc_q) < PSC_MIN + PSC_STEP) ? PSC_FLOOR : psc_q - PSC_DEC;
          end else if (xdir_q && bx_right == HIT2_X && ovl2) begin
            xdir_n = 1'b0;
            bx_n   = ball_x - 10'd1;
            hit_n  = 1'b1;
            psc_n  = (int'(psc_q) < PSC_MIN + PSC_STEP) ? PSC_FLOOR : psc_q - PSC_DEC;
          end else if (!xdir_q && ball_x == 10'd0) begin
            // P2 scores; next serve heads back toward P1.
            pp2_n  = 1'b1;
            s2_n   = s2_inc;
            bx_n   = BX0;
            by_n   = BY0;
            psc_n  = PSC0;
            xdir_n = 1'b0;
            if (s2_inc == SCORE_WIN) begin
              st_n  = OVER;
              win_n = 1'b1;
            end else begin
              st_n = SERVE;
            end
          end else if (xdir_q && ball_x == X_MAX) begin
            // P1 scores; next serve heads toward P2.
            pp1_n  = 1'b1;
            s1_n   = s1_inc;
            bx_n   = BX0;
            by_n   = BY0;
            psc_n  = PSC0;
            xdir_n = 1'b1;
            if (s1_inc == SCORE_WIN) begin
              st_n  = OVER;
              win_n = 1'b0;
            end else begin
              st_n = SERVE;
            end
          end else begin
            bx_n = xdir_q ? ball_x + 10'd1 : ball_x - 10'd1;
          end
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // Ball, prescaler, scores and pulse registers.
  always_ff @(posedge clk_0) begin
    if (rst) begin
      ball_x   <= BX0;
      ball_y   <= BY0;
      cnt_q    <= '0;
      psc_q    <= PSC0;
      xdir_q   <= 1'b0;
      ydir_q   <= 1'b0;
      score1   <= '0;
      score2   <= '0;
      winner   <= 1'b0;
      point_p1 <= 1'b0;
      point_p2 <= 1'b0;
      hit      <= 1'b0;
    end else begin
      ball_x   <= bx_n;
      ball_y   <= by_n;
      cnt_q    <= cnt_n;
      psc_q    <= psc_n;
      xdir_q   <= xdir_n;
      ydir_q   <= ydir_n;
      score1   <= s1_n;
      score2   <= s2_n;
      winner   <= win_n;
      point_p1 <= pp1_n;
      point_p2 <= pp2_n;
      hit      <= hit_n;
    end
  end

  // One clamped pixel step; up_b is the active-low up button of the pair.
  function automatic logic [9:0] pdl_next(input logic [9:0] y, input logic up_b);
    if (!up_b) return (y == 10'd0) ? y : y - 10'd1;
    else       return (y >= PY_MAX) ? y : y + 10'd1;
  endfunction

  // Exactly one button of a pair held low moves that paddle.
  assign mv1 = up_p1 ^ down_p1;
  assign mv2 = up_p2 ^ down_p2;

  // Paddle prescalers and positions; paddles move in every game state.
  always_ff @(posedge clk_0) begin
    if (rst) begin
      pdl1_y <= PY0;
      pdl2_y <= PY0;
      pc1_q  <= '0;
      pc2_q  <= '0;
    end else begin
      if (!mv1) begin
        pc1_q <= '0;
      end else if (pc1_q == PDL_LAST) begin
        pc1_q  <= '0;
        pdl1_y <= pdl_next(pdl1_y, up_p1);
      end else begin
        pc1_q <= pc1_q + PW'(1);
      end
      if (!mv2) begin
        pc2_q <= '0;
      end else if (pc2_q == PDL_LAST) begin
        pc2_q  <= '0;
        pdl2_y <= pdl_next(pdl2_y, up_p2);
      end else begin
        pc2_q <= pc2_q + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed match on a scaled-down clock. Stimulus queues the
// expected game events; a negedge monitor pops and compares each event the
// engine presents (state change, hit or point pulse), including its spacing.
module tb_pong_engine;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       up_p1 = 1'b1, down_p1 = 1'b1, up_p2 = 1'b1, down_p2 = 1'b1;
  logic [9:0] ball_x, ball_y, pdl1_y, pdl2_y;
  logic [3:0] score1, score2;
  logic [1:0] state;
  logic       winner, point_p1, point_p2, hit;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   ev_idx = 0;
  bit   mon_en = 1'b0;
  logic [1:0] prev_st = 2'd0;

  typedef struct {
    int st; int h; int p1; int p2;
    int x;  int y; int s1; int s2; int w;
    int dt;                                  // cycles since previous event, -1 = unchecked
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;

  pong_engine #(
    .CLK_HZ(1000), .BALL_VEL(100), .PDL_VEL(100), .SERVE_CYCLES(20),
    .WIN_SCORE(2), .PSC_STEP(3), .PSC_MIN(4)
  ) dut (
    .clk_0(clk_0), .rst(rst), .start(start),
    .up_p1(up_p1), .down_p1(down_p1), .up_p2(up_p2), .down_p2(down_p2),
    .ball_x(ball_x), .ball_y(ball_y), .pdl1_y(pdl1_y), .pdl2_y(pdl2_y),
    .score1(score1), .score2(score2), .state(state), .winner(winner),
    .point_p1(point_p1), .point_p2(point_p2), .hit(hit)
  );

  always #5 clk_0 = ~clk_0;
  always @(posedge clk_0) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_0);
    #1;
  endtask

  task automatic push_ev(input int st, input int h, input int p1, input int p2,
                         input int x, input int y, input int s1, input int s2,
                         input int w, input int dt);
    ev_t e;
    e.st = st; e.h = h; e.p1 = p1; e.p2 = p2;
    e.x = x; e.y = y; e.s1 = s1; e.s2 = s2; e.w = w; e.dt = dt;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_ball"}, 32'({ball_x, ball_y}), 312 * 1024 + 232);
    check({tag, "_pdl1"}, 32'(pdl1_y), 192);
    check({tag, "_pdl2"}, 32'(pdl2_y), 192);
    check({tag, "_scores"}, 32'({score1, score2, winner}), 0);
    check({tag, "_pulses"}, 32'({hit, point_p1, point_p2}), 0);
  endtask

  // Monitor: every state change or event pulse must match the next queued event.
  always @(negedge clk_0) begin
    if (mon_en && (state !== prev_st || hit === 1'b1 || point_p1 === 1'b1 || point_p2 === 1'b1)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL ev%0d_unexpected: state=%0d hit=%0b p1=%0b p2=%0b ball=(%0d,%0d), no event queued",
                 ev_idx + 1, state, hit, point_p1, point_p2, ball_x, ball_y);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("ev%0d_kind", ev_idx + 1), 32'({state, hit, point_p1, point_p2}),
              32'(mon_e.st * 8 + mon_e.h * 4 + mon_e.p1 * 2 + mon_e.p2));
        check($sformatf("ev%0d_ball", ev_idx + 1), 32'({ball_x, ball_y}),
              32'(mon_e.x * 1024 + mon_e.y));
        check($sformatf("ev%0d_scores", ev_idx + 1), 32'({score1, score2, winner}),
              32'(mon_e.s1 * 32 + mon_e.s2 * 2 + mon_e.w));
        if (mon_e.dt >= 0)
          check($sformatf("ev%0d_spacing", ev_idx + 1), 32'(cyc - last_cyc), 32'(mon_e.dt));
      end
      ev_idx   <= ev_idx + 1;
      last_cyc <= cyc;
    end
    prev_st <= state;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state.
    tick(3);
    rst = 1'b0;
    check_reset_outputs("reset");
    tick(2);
    mon_en = 1'b1;

    // Paddles in IDLE: pdl1 up to the top clamp, pdl2 both buttons low.
    up_p1 = 1'b0; up_p2 = 1'b0; down_p2 = 1'b0;
    tick(1919);
    check("pdl1_one_px_left", 32'(pdl1_y), 1);
    check("pdl2_both_low", 32'(pdl2_y), 192);
    tick(1);
    check("pdl1_at_top", 32'(pdl1_y), 0);
    tick(50);
    check("pdl1_clamped", 32'(pdl1_y), 0);
    up_p1 = 1'b1; up_p2 = 1'b1;
    tick(599);
    check("pdl2_down_599", 32'(pdl2_y), 251);
    tick(1);
    check("pdl2_down_600", 32'(pdl2_y), 252);
    down_p2 = 1'b1;
    tick(30);
    check("pdl2_released", 32'(pdl2_y), 252);

    // First match: three hits with speed-up, then P1 wins 2-0.
    push_ev(1, 0, 0, 0, 312, 232, 0, 0, 0, -1);   // start -> SERVE
    push_ev(2, 0, 0, 0, 312, 232, 0, 0, 0, 20);   // serve lasts 20 cycles
    push_ev(2, 1, 0, 0,  37,  45, 0, 0, 0, 2770); // hit pdl1, 277 steps x 10
    push_ev(2, 1, 0, 0, 586, 332, 0, 0, 0, 3857); // hit pdl2, 551 steps x 7
    push_ev(2, 1, 0, 0,  37, 219, 0, 0, 0, 2204); // hit pdl1, 551 steps x 4
    push_ev(1, 0, 1, 0, 312, 232, 1, 0, 0, 2352); // P1 point, 588 steps x 4 (floor)
    push_ev(2, 0, 0, 0, 312, 232, 1, 0, 0, 20);
    push_ev(3, 0, 1, 0, 312, 232, 2, 0, 0, 3130); // P1 wins, 313 steps x 10
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(20);
    tick(9);
    check("first_step_pending", 32'({ball_x, ball_y}), 312 * 1024 + 232);
    tick(1);
    check("first_step", 32'({ball_x, ball_y}), 311 * 1024 + 231);

    n = 0;
    while (hit !== 1'b1 && n < 4000) begin tick(1); n++; end
    check("hit1_seen", 32'(hit), 1);
    // Bring pdl1 down to y=150 so it meets the ball on its next return.
    down_p1 = 1'b0;
    tick(1500);
    down_p1 = 1'b1;
    check("pdl1_down_150", 32'(pdl1_y), 150);

    n = 0;
    while (state !== 2'd3 && n < 15000) begin tick(1); n++; end
    check("over_reached", 32'(state), 3);
    tick(5);
    check("over_ball_frozen", 32'({ball_x, ball_y}), 312 * 1024 + 232);
    check("over_scores_frozen", 32'({score1, score2, winner}), 2 * 32);

    // Rematch: scores clear, P2 scores past the raised pdl1, serve goes left.
    push_ev(1, 0, 0, 0, 312, 232, 0, 0, 0, -1);
    push_ev(2, 0, 0, 0, 312, 232, 0, 0, 0, 20);
    push_ev(1, 0, 0, 1, 312, 232, 0, 1, 0, 3130);
    push_ev(2, 0, 0, 0, 312, 232, 0, 1, 0, 20);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (!(state === 2'd1 && score2 === 4'd1) && n < 5000) begin tick(1); n++; end
    check("p2_point_serve", 32'({state, score2}), 32'({2'd1, 4'd1}));
    n = 0;
    while (state !== 2'd2 && n < 100) begin tick(1); n++; end
    check("second_serve_play", 32'(state), 2);
    tick(10);
    check("serve_toward_p1", 32'({ball_x, ball_y}), 311 * 1024 + 231);

    // Reset in the middle of play.
    tick(5);
    push_ev(0, 0, 0, 0, 312, 232, 0, 0, 0, -1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset_outputs("midplay_reset");
    tick(3);
    check("events_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
